// File: rtl/stage2_pkg.sv
// Shared definitions for the stage-2 type/control pipe.
// Contents:
//   - ASCII constants for the category and type bytes
//   - N-type, mux and block-size codes, and their field widths
//   - skid-buffer state encoding
//   - width helpers for the beat-level count and byte-total fields
package stage2_pkg;

  localparam logic [7:0] CH_NONE = 8'h00;
  localparam logic [7:0] CH_A    = 8'h61;  // 'a'
  localparam logic [7:0] CH_D    = 8'h64;  // 'd'
  localparam logic [7:0] CH_K    = 8'h6B;  // 'k'
  localparam logic [7:0] CH_Q    = 8'h71;  // 'q'
  localparam logic [7:0] CH_N    = 8'h4E;  // 'N'
  localparam logic [7:0] CH_L    = 8'h4C;  // 'L'
  localparam logic [7:0] CH_M    = 8'h4D;  // 'M'
  localparam logic [7:0] CH_R    = 8'h52;  // 'R'
  localparam logic [7:0] CH_S    = 8'h53;  // 'S'

  localparam int NTYPE_W = 3;
  localparam int MUX_W   = 3;
  localparam int BSIZE_W = 6;

  typedef enum logic [NTYPE_W-1:0] {
    NT_OTHER = 3'd0,
    NT_L     = 3'd1,
    NT_M     = 3'd2,
    NT_N     = 3'd3,
    NT_R     = 3'd4,
    NT_S     = 3'd5
  } n_type_e;

  typedef enum logic [MUX_W-1:0] {
    MUX_OTHER = 3'd0,
    MUX_A     = 3'd1,
    MUX_D     = 3'd2,
    MUX_K     = 3'd3,
    MUX_Q     = 3'd4,
    MUX_N     = 3'd5
  } mux_e;

  localparam logic [BSIZE_W-1:0] BS_OTHER = 6'd0;
  localparam logic [BSIZE_W-1:0] BS_A     = 6'd35;
  localparam logic [BSIZE_W-1:0] BS_D     = 6'd22;
  localparam logic [BSIZE_W-1:0] BS_K     = 6'd35;
  localparam logic [BSIZE_W-1:0] BS_Q     = 6'd21;
  localparam logic [BSIZE_W-1:0] BS_N     = 6'd12;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic int count_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Largest block size is 35, so a full beat totals at most 35*lanes.
  function automatic int byte_total_w(input int lanes);
    return $clog2(35 * lanes + 1);
  endfunction

endpackage

// File: rtl/stage2_type_control_pipe_if.sv
// Bus between the stage-1 header splitter, this pipe and the stage-3
// field extractors.
//   master : drives in_valid/in_sop/in_seq_start/in_category/in_type and
//            out_ready; observes in_ready, out_* and dbg_state.
//   slave  : the pipe itself (the opposite directions).
// Handshake: a beat transfers on a rising clock edge where valid && ready.
// A sender holding valid keeps its data stable until the transfer; ready
// may be asserted with or without valid and never depends on valid
// combinationally across the pipe.
interface stage2_type_control_pipe_if
  import stage2_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int SEQ_W     = 32
);
  localparam int CNT_W  = count_w(NUM_LANES);
  localparam int BYTE_W = byte_total_w(NUM_LANES);

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_sop;
  logic [SEQ_W-1:0]              in_seq_start;
  logic [8*NUM_LANES-1:0]        in_category;
  logic [8*NUM_LANES-1:0]        in_type;

  logic                          out_valid;
  logic                          out_ready;
  logic [NTYPE_W*NUM_LANES-1:0]  out_n_type;
  logic [MUX_W*NUM_LANES-1:0]    out_mux;
  logic [BSIZE_W*NUM_LANES-1:0]  out_block_size;
  logic [NUM_LANES-1:0]          out_lane_valid;
  logic [CNT_W-1:0]              out_msg_count;
  logic [BYTE_W-1:0]             out_byte_total;
  logic                          out_seq_ok;
  logic [SEQ_W-1:0]              out_seq_base;
  logic                          out_err;

  buf_state_e                    dbg_state;

  modport master (
    output in_valid, in_sop, in_seq_start, in_category, in_type, out_ready,
    input  in_ready, out_valid, out_n_type, out_mux, out_block_size,
           out_lane_valid, out_msg_count, out_byte_total, out_seq_ok,
           out_seq_base, out_err, dbg_state
  );

  modport slave (
    input  in_valid, in_sop, in_seq_start, in_category, in_type, out_ready,
    output in_ready, out_valid, out_n_type, out_mux, out_block_size,
           out_lane_valid, out_msg_count, out_byte_total, out_seq_ok,
           out_seq_base, out_err, dbg_state
  );

endinterface

// File: rtl/stage2_lane_decode.sv
// Single-lane header decode, purely combinational.
// Ports:
//   category, type_byte : ASCII header bytes of one lane
//   n_type, mux, block_size : lane fields, zero when category is none
//   lane_valid : category is not none
//   is_n       : category is 'N'
//   unknown    : category is non-none and not one of a/d/k/q/N
module stage2_lane_decode
  import stage2_pkg::*;
(
  input  logic [7:0]         category,
  input  logic [7:0]         type_byte,
  output logic [NTYPE_W-1:0] n_type,
  output logic [MUX_W-1:0]   mux,
  output logic [BSIZE_W-1:0] block_size,
  output logic               lane_valid,
  output logic               is_n,
  output logic               unknown
);

  always_comb begin
    n_type     = NT_OTHER;
    mux        = MUX_OTHER;
    block_size = BS_OTHER;
    unknown    = 1'b0;
    lane_valid = (category != CH_NONE);
    is_n       = (category == CH_N);
    if (lane_valid) begin
      // The type byte is decoded on its own; the category only gates it.
      case (type_byte)
        CH_L:    n_type = NT_L;
        CH_M:    n_type = NT_M;
        CH_N:    n_type = NT_N;
        CH_R:    n_type = NT_R;
        CH_S:    n_type = NT_S;
        default: n_type = NT_OTHER;
      endcase
      case (category)
        CH_A: begin mux = MUX_A; block_size = BS_A; end
        CH_D: begin mux = MUX_D; block_size = BS_D; end
        CH_K: begin mux = MUX_K; block_size = BS_K; end
        CH_Q: begin mux = MUX_Q; block_size = BS_Q; end
        CH_N: begin mux = MUX_N; block_size = BS_N; end
        default: unknown = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/stage2_type_control_pipe.sv
// Registered stage-2 per-message decode with a one-entry skid buffer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of stage2_type_control_pipe_if carrying the input
//              beat (categories, types, sop, sequence start), the decoded
//              output beat, both handshakes and the buffer state.
// Each accepted beat is decoded combinationally and captured either into
// the output register or, when the output is stalled, into the skid
// register. in_ready and out_valid come straight from flops.
module stage2_type_control_pipe
  import stage2_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int SEQ_W     = 32
) (
  input logic clk,
  input logic rst,
  stage2_type_control_pipe_if.slave bus
);

  localparam int CNT_W  = count_w(NUM_LANES);
  localparam int BYTE_W = byte_total_w(NUM_LANES);
  localparam int BEAT_W = (NTYPE_W + MUX_W + BSIZE_W + 1) * NUM_LANES
                          + CNT_W + BYTE_W + 1 + SEQ_W + 1;

  // Per-lane decode.
  logic [NTYPE_W*NUM_LANES-1:0] n_type_v;
  logic [MUX_W*NUM_LANES-1:0]   mux_v;
  logic [BSIZE_W*NUM_LANES-1:0] bsize_v;
  logic [NUM_LANES-1:0]         lane_valid_v;
  logic [NUM_LANES-1:0]         lane_is_n_v;
  logic [NUM_LANES-1:0]         lane_unknown_v;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    stage2_lane_decode u_lane_decode (
      .category   (bus.in_category[8*g +: 8]),
      .type_byte  (bus.in_type[8*g +: 8]),
      .n_type     (n_type_v[NTYPE_W*g +: NTYPE_W]),
      .mux        (mux_v[MUX_W*g +: MUX_W]),
      .block_size (bsize_v[BSIZE_W*g +: BSIZE_W]),
      .lane_valid (lane_valid_v[g]),
      .is_n       (lane_is_n_v[g]),
      .unknown    (lane_unknown_v[g])
    );
  end

  // Beat-level aggregation. Lanes with category none already report zero
  // block size, so only lane_valid needs masking for the count.
  logic [CNT_W-1:0]  msg_cnt;
  logic [BYTE_W-1:0] byte_sum;

  always_comb begin
    msg_cnt  = '0;
    byte_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      msg_cnt  = msg_cnt + CNT_W'(lane_valid_v[i]);
      byte_sum = byte_sum + BYTE_W'(bsize_v[BSIZE_W*i +: BSIZE_W]);
    end
  end

  // Sequence and error bookkeeping: in_sop restarts both.
  logic [SEQ_W-1:0] seq_q;
  logic             err_q;
  logic [SEQ_W-1:0] beat_base;
  logic             beat_err;
  logic             in_ready_q;
  logic             accept;

  assign accept    = bus.in_valid && in_ready_q;
  assign beat_base = bus.in_sop ? bus.in_seq_start : seq_q;
  assign beat_err  = (bus.in_sop ? 1'b0 : err_q) | (|lane_unknown_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      seq_q <= beat_base + SEQ_W'(msg_cnt);  // wraps silently
      err_q <= beat_err;
    end
  end

  logic [BEAT_W-1:0] beat_d;
  assign beat_d = {n_type_v, mux_v, bsize_v, lane_valid_v, msg_cnt, byte_sum,
                   ~(|lane_is_n_v), beat_base, beat_err};

  // Skid-buffer FSM.
  buf_state_e state_q, state_d;
  logic       load_out, load_skid, skid_to_out;
  logic       out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_TWO);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && bus.out_ready) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = BUF_TWO;
        end else if (bus.out_ready) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // in_ready is low here, so no new beat can collide with the move.
        if (bus.out_ready) begin
          skid_to_out = 1'b1;
          state_d     = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Data registers.
  logic [BEAT_W-1:0] out_q;
  logic [BEAT_W-1:0] skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)         out_q <= beat_d;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= beat_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dbg_state = state_q;
  assign {bus.out_n_type, bus.out_mux, bus.out_block_size, bus.out_lane_valid,
          bus.out_msg_count, bus.out_byte_total, bus.out_seq_ok,
          bus.out_seq_base, bus.out_err} = out_q;

endmodule

// File: tb/tb_stage2_type_control_pipe.sv
// Bench for stage2_type_control_pipe: three instances (3, 1 and 8 lanes)
// share one stimulus stream and one handshake timing. Every beat offered is
// fed through a reference model built from the decode tables and the
// sequence/error rules; the per-instance expected queues are checked as
// beats leave, and buffer occupancy predicts in_ready/out_valid.
module tb_stage2_type_control_pipe;
  import stage2_pkg::*;

  localparam int EW = 24 + 24 + 48 + 8 + 4 + 9 + 1 + 32 + 1;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic        in_valid;
  logic        in_sop;
  logic [31:0] seq_start;
  logic [63:0] cat;
  logic [63:0] typ;
  logic        out_ready;

  stage2_type_control_pipe_if #(.NUM_LANES(3), .SEQ_W(32)) if3 ();
  stage2_type_control_pipe_if #(.NUM_LANES(1), .SEQ_W(32)) if1 ();
  stage2_type_control_pipe_if #(.NUM_LANES(8), .SEQ_W(32)) if8 ();

  assign if3.in_valid = in_valid;  assign if3.in_sop = in_sop;
  assign if3.in_seq_start = seq_start;  assign if3.out_ready = out_ready;
  assign if3.in_category = cat[23:0];   assign if3.in_type = typ[23:0];
  assign if1.in_valid = in_valid;  assign if1.in_sop = in_sop;
  assign if1.in_seq_start = seq_start;  assign if1.out_ready = out_ready;
  assign if1.in_category = cat[7:0];    assign if1.in_type = typ[7:0];
  assign if8.in_valid = in_valid;  assign if8.in_sop = in_sop;
  assign if8.in_seq_start = seq_start;  assign if8.out_ready = out_ready;
  assign if8.in_category = cat;         assign if8.in_type = typ;

  stage2_type_control_pipe #(.NUM_LANES(3), .SEQ_W(32)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
  stage2_type_control_pipe #(.NUM_LANES(1), .SEQ_W(32)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  stage2_type_control_pipe #(.NUM_LANES(8), .SEQ_W(32)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  // scoreboard state
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  int          lanes[3] = '{3, 1, 8};
  logic [31:0] mseq[3];
  logic        merr[3];
  int          occ[3];
  logic        hold[3];
  logic [EW-1:0] last[3];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [EW-1:0] o, input logic [EW-1:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // reference model
  function automatic int find_idx(input string s, input logic [7:0] c);
    for (int i = 0; i < s.len(); i++)
      if (s[i] == byte'(c)) return i + 1;
    return 0;
  endfunction

  function automatic logic [EW-1:0] ref_beat(
    input int lanes_n, input logic [63:0] c_v, input logic [63:0] t_v,
    input logic sop, input logic [31:0] start, input logic [31:0] seq_in,
    input logic err_in, output logic [31:0] seq_out, output logic err_out);
    int          size_tab[6];
    logic [23:0] nt;
    logic [23:0] mx;
    logic [47:0] bs;
    logic [7:0]  lv;
    int          cnt;
    int          bytes;
    int          m;
    logic        ok;
    logic        unk;
    logic [31:0] base;
    size_tab = '{0, 35, 22, 35, 21, 12};
    nt = '0; mx = '0; bs = '0; lv = '0; cnt = 0; bytes = 0; ok = 1'b1; unk = 1'b0;
    for (int i = 0; i < lanes_n; i++) begin
      if (c_v[8*i +: 8] != 8'h00) begin
        m = find_idx("adkqN", c_v[8*i +: 8]);
        lv[i] = 1'b1;
        cnt++;
        nt[3*i +: 3] = 3'(find_idx("LMNRS", t_v[8*i +: 8]));
        mx[3*i +: 3] = 3'(m);
        bs[6*i +: 6] = 6'(size_tab[m]);
        bytes += size_tab[m];
        if (m == 0) unk = 1'b1;
        if (m == 5) ok = 1'b0;
      end
    end
    base    = sop ? start : seq_in;
    seq_out = base + 32'(cnt);
    err_out = (sop ? 1'b0 : err_in) | unk;
    return {nt, mx, bs, lv, 4'(cnt), 9'(bytes), ok, base, err_out};
  endfunction

  // DUT views
  function automatic logic [EW-1:0] obs(input int d);
    case (d)
      0: return {24'(if3.out_n_type), 24'(if3.out_mux), 48'(if3.out_block_size),
                 8'(if3.out_lane_valid), 4'(if3.out_msg_count), 9'(if3.out_byte_total),
                 if3.out_seq_ok, if3.out_seq_base, if3.out_err};
      1: return {24'(if1.out_n_type), 24'(if1.out_mux), 48'(if1.out_block_size),
                 8'(if1.out_lane_valid), 4'(if1.out_msg_count), 9'(if1.out_byte_total),
                 if1.out_seq_ok, if1.out_seq_base, if1.out_err};
      default: return {24'(if8.out_n_type), 24'(if8.out_mux), 48'(if8.out_block_size),
                 8'(if8.out_lane_valid), 4'(if8.out_msg_count), 9'(if8.out_byte_total),
                 if8.out_seq_ok, if8.out_seq_base, if8.out_err};
    endcase
  endfunction

  function automatic logic [1:0] ctl(input int d);  // {out_valid, in_ready}
    case (d)
      0: return {if3.out_valid, if3.in_ready};
      1: return {if1.out_valid, if1.in_ready};
      default: return {if8.out_valid, if8.in_ready};
    endcase
  endfunction

  task automatic q_push(input int d, input logic [EW-1:0] e);
    case (d)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int d, output logic [EW-1:0] e, output logic ok);
    e = '0;
    ok = 1'b0;
    case (d)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic clear_model();
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    for (int d = 0; d < 3; d++) begin
      mseq[d] = '0; merr[d] = 1'b0; occ[d] = 0; hold[d] = 1'b0; last[d] = '0;
    end
  endtask

  // Check everything observable before the coming edge, update the model
  // with what transfers on it, then advance to just after the edge.
  task automatic tick();
    logic [1:0]    c;
    logic [EW-1:0] o;
    logic [EW-1:0] e;
    logic [31:0]   sn;
    logic          en;
    logic          ok;
    for (int d = 0; d < 3; d++) begin
      c = ctl(d);
      o = obs(d);
      chk($sformatf("d%0d_in_ready", d), 64'(c[0]), 64'(occ[d] < 2));
      chk($sformatf("d%0d_out_valid", d), 64'(c[1]), 64'(occ[d] > 0));
      if (hold[d] && c[1]) chk_beat($sformatf("d%0d_stable", d), o, last[d]);
      hold[d] = c[1] && !out_ready;
      last[d] = o;
      if (c[1] && out_ready) begin
        q_pop(d, e, ok);
        chk($sformatf("d%0d_unexpected_beat", d), 64'(ok), 64'd1);
        if (ok) chk_beat($sformatf("d%0d_beat", d), o, e);
        if (occ[d] > 0) occ[d]--;
      end
      if (in_valid && c[0]) begin
        e = ref_beat(lanes[d], cat, typ, in_sop, seq_start, mseq[d], merr[d], sn, en);
        mseq[d] = sn;
        merr[d] = en;
        q_push(d, e);
        occ[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_cat();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return "a";
      2: return "d";
      3: return "k";
      4: return "q";
      5: return "N";
      6: return "z";
      default: return 8'($urandom_range(1, 255));
    endcase
  endfunction

  function automatic logic [7:0] rnd_typ();
    case ($urandom_range(0, 6))
      0: return "L";
      1: return "M";
      2: return "N";
      3: return "R";
      4: return "S";
      5: return "X";
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; seq_start = '0;
    cat = '0; typ = '0; out_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // reset state
    chk("rst_out_valid", 64'(if3.out_valid), 64'd0);
    chk("rst_in_ready", 64'(if3.in_ready), 64'd1);
    chk("rst_state", 64'(if3.dbg_state), 64'(BUF_EMPTY));
    chk_beat("rst_data", obs(0), '0);

    // first beat {a,d,q} / {L,S,X}, sop, start 100
    in_valid = 1'b1; in_sop = 1'b1; seq_start = 32'd100;
    cat = {40'h0, "q", "d", "a"}; typ = {40'h0, "X", "S", "L"};
    tick();
    chk("t1_out_valid", 64'(if3.out_valid), 64'd1);
    chk("t1_block_size", 64'(if3.out_block_size), 64'({6'd21, 6'd22, 6'd35}));
    chk("t1_n_type", 64'(if3.out_n_type), 64'({3'd0, 3'd5, 3'd1}));
    chk("t1_mux", 64'(if3.out_mux), 64'({3'd4, 3'd2, 3'd1}));
    chk("t1_lane_valid", 64'(if3.out_lane_valid), 64'd7);
    chk("t1_msg_count", 64'(if3.out_msg_count), 64'd3);
    chk("t1_byte_total", 64'(if3.out_byte_total), 64'd78);
    chk("t1_seq_base", 64'(if3.out_seq_base), 64'd100);
    chk("t1_seq_ok", 64'(if3.out_seq_ok), 64'd1);
    chk("t1_err", 64'(if3.out_err), 64'd0);
    in_sop = 1'b0; cat = {40'h0, "k", "k", "d"}; typ = 64'({$urandom, $urandom});
    tick();
    chk("t1_next_seq_base", 64'(if3.out_seq_base), 64'd103);
    in_valid = 1'b0;
    tick(); tick();

    // stall: {none,N,k} then one more beat fills the skid
    out_ready = 1'b0; in_valid = 1'b1;
    cat = {40'h0, "k", "N", 8'h00}; typ = {40'h0, "L", "R", "M"};
    tick();
    chk("t2_in_ready_after_first", 64'(if3.in_ready), 64'd1);
    cat = {40'h0, "a", "q", "d"}; typ = 64'({$urandom, $urandom});
    tick();
    chk("t2_in_ready_low", 64'(if3.in_ready), 64'd0);
    chk("t2_state_two", 64'(if3.dbg_state), 64'(BUF_TWO));
    cat = {40'h0, "N", "a", "k"}; typ = 64'({$urandom, $urandom});
    tick();
    chk("t2_msg_count", 64'(if3.out_msg_count), 64'd2);
    chk("t2_byte_total", 64'(if3.out_byte_total), 64'd47);
    chk("t2_seq_ok", 64'(if3.out_seq_ok), 64'd0);
    chk("t2_mux", 64'(if3.out_mux), 64'({3'd3, 3'd5, 3'd0}));
    chk("t2_none_n_type", 64'(if3.out_n_type[2:0]), 64'd0);
    out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();

    // sticky error
    in_valid = 1'b1; in_sop = 1'b0;
    cat = {40'h0, "a", "a", "z"}; typ = 64'({$urandom, $urandom});
    tick();
    chk("t3_err_set", 64'(if3.out_err), 64'd1);
    cat = {40'h0, "d", "k", "a"};
    tick();
    chk("t3_err_sticky", 64'(if3.out_err), 64'd1);
    in_sop = 1'b1; seq_start = 32'd500; cat = {40'h0, "q", "q", "a"};
    tick();
    chk("t3_err_clear", 64'(if3.out_err), 64'd0);

    // sequence wrap
    in_sop = 1'b1; seq_start = 32'hFFFF_FFFB; cat = {40'h0, "a", "a", "a"};
    tick();
    in_sop = 1'b0; cat = {40'h0, "q", "k", "d"};
    tick();
    chk("t4_base_pre_wrap", 64'(if3.out_seq_base), 64'hFFFF_FFFE);
    cat = {40'h0, "a", "d", "k"};
    tick();
    chk("t4_base_wrapped", 64'(if3.out_seq_base), 64'd1);
    in_sop = 1'b1; seq_start = 32'hFFFF_FFFF; cat = {40'h0, "a", "a", "a"};
    tick();
    chk("t4_sop_base", 64'(if3.out_seq_base), 64'hFFFF_FFFF);
    in_sop = 1'b0;
    tick();
    chk("t4_sop_wrap_base", 64'(if3.out_seq_base), 64'd2);
    in_valid = 1'b0;
    tick(); tick();

    // reset while both registers hold beats
    out_ready = 1'b0; in_valid = 1'b1; in_sop = 1'b0; cat = {40'h0, "a", "d", "k"};
    tick(); tick();
    chk("t5_state_two", 64'(if3.dbg_state), 64'(BUF_TWO));
    #2 rst = 1'b1;
    #1;
    chk("t5_async_out_valid", 64'(if3.out_valid), 64'd0);
    chk("t5_async_in_ready", 64'(if3.in_ready), 64'd1);
    chk("t5_async_state", 64'(if3.dbg_state), 64'(BUF_EMPTY));
    chk_beat("t5_async_data", obs(0), '0);
    clear_model();
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_sop = 1'b0; cat = {40'h0, "a", "a", "a"};
    tick();
    chk("t5_post_reset_base", 64'(if3.out_seq_base), 64'd0);
    in_valid = 1'b0;
    tick();

    // random valid/ready stress across all three widths
    for (int n = 0; n < 1000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sop    = ($urandom_range(0, 7) == 0);
      seq_start = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : $urandom;
      for (int i = 0; i < 8; i++) begin
        cat[8*i +: 8] = rnd_cat();
        typ[8*i +: 8] = rnd_typ();
      end
      tick();
    end

    // drain with a bounded budget
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && (occ[0] + occ[1] + occ[2]) > 0; i++) tick();
    chk("drain_q3", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);
    chk("drain_q8", 64'(exp_q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stage2_type_control_pipe.md
# stage2_type_control_pipe

Parametrised, registered successor to the stage-2 per-message decode. It accepts one beat of up to NUM_LANES message headers (category and type bytes) per accepted handshake. For each lane it produces N-type code, message-mux select, block size and block control, and for the beat it produces message count, byte total and sequence bookkeeping. It sits between the stage-1 header splitter and the stage-3 field extractors, with valid/ready on both sides and a one-entry skid buffer so in_ready is a register output.

## Interface
- NUM_LANES, 3, message lanes per beat (1..8)
- SEQ_W, 32, sequence counter width
- BYTE_W, derived = clog2(35*NUM_LANES+1), beat byte-total width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_sop  in  1  first beat of a packet; qualifies in_seq_start
- in_seq_start  in  SEQ_W  packet starting sequence number
- in_category  in  8*NUM_LANES  lane i at [8i+7:8i], ASCII
- in_type  in  8*NUM_LANES  lane i type byte, ASCII
- out_valid  out  1  decoded beat present
- out_ready  in  1  downstream accepts
- out_n_type  out  3*NUM_LANES  L=1 M=2 N=3 R=4 S=5, other=0
- out_mux  out  3*NUM_LANES  a=1 d=2 k=3 q=4 N=5, other=0
- out_block_size  out  6*NUM_LANES  a=35 d=22 k=35 q=21 N=12, other=0
- out_lane_valid  out  NUM_LANES  category != none (8'h00)
- out_msg_count  out  clog2(NUM_LANES+1)  popcount of out_lane_valid
- out_byte_total  out  BYTE_W  sum of lane block sizes
- out_seq_ok  out  1  no lane carries category N
- out_seq_base  out  SEQ_W  sequence number of the first valid lane in the beat
- out_err  out  1  sticky: some non-none lane had an unknown category since the last in_sop

## Operation
- The decode is purely combinational on the input beat. Results are captured into the output register or the skid register.
- Buffer FSM has three states:
  - EMPTY: out_valid=0, in_ready=1. An accept moves to ONE.
  - ONE: out_valid=1, in_ready=1.
    - accept && out_ready: reload the output register, stay in ONE.
    - accept && !out_ready: write the skid, go to TWO.
    - !accept && out_ready: go to EMPTY.
  - TWO: in_ready=0. out_ready moves the skid into the output register and goes to ONE.
- Sequence counter seq_q:
  - On an accepted beat with in_sop, the beat's base is in_seq_start.
  - On an accepted beat without in_sop, the base is seq_q.
  - After every accept, seq_q = base + out_msg_count of that beat, modulo 2^SEQ_W (wraps without a flag).
- Error flag err_q:
  - A lane is unknown when its category is non-none and not one of a/d/k/q/N.
  - On an accept with in_sop, err_q = unknown-in-this-beat.
  - On an accept without in_sop, err_q |= unknown-in-this-beat.
  - out_err is the err_q value captured together with the beat.
- Lanes with category none report zeros in n_type, mux and block_size, and contribute nothing to the count or byte total.
- Types are decoded independently of category.

## Timing
- Latency: an accept at edge k makes the beat visible at out_* after edge k. Throughput is one beat per cycle while out_ready=1.
- Reset values: out_valid=0, in_ready=1, all out_* data=0, seq_q=0, err_q=0, FSM=EMPTY.
- Reset asserted mid-operation drops any held beats immediately, with no flush.
- Handshakes:
  - out_* data is stable while out_valid && !out_ready.
  - in_ready never depends combinationally on out_ready.
  - Data is never lost or duplicated in the TWO state.
- When in_sop and a wrap occur on the same beat, in_seq_start wins.

## Structure
- A shared package stage2_pkg holds:
  - ASCII constants: a, d, k, q, N, L, M, R, S, none.
  - N-type, mux and block-size codes, and their field widths.
- One sub-module, stage2_lane_decode: one 8-bit category plus one 8-bit type in, lane fields plus unknown out. It is instantiated NUM_LANES times in a generate loop.
- The skid FSM and the sequence/error bookkeeping stay in the top module.

## Test plan
- Reset, then a beat with categories {a,d,q}, types {L,S,X}, in_sop=1, in_seq_start=100 -> one cycle later:
  - block sizes {35,22,21}, n_type {1,5,0}, msg_count=3, byte_total=78
  - seq_base=100, seq_ok=1, err=0
  - the next non-sop beat has seq_base=103.
- Categories {none,N,k}, no sop, out_ready held 0 for 3 cycles while sending 2 more beats -> in_ready drops after the second accept. All three beats then emerge in order with stable data. For the first beat: msg_count=2, byte_total=47, seq_ok=0.
- Category {z,a,a} on a non-sop beat -> err=1, remaining on later beats. The next in_sop beat with clean lanes -> err=0.
- seq_q=2^32-2 and a 3-message beat -> next seq_base=1.
- Assert rst while in state TWO -> out_valid=0 and in_ready=1 asynchronously. The first post-reset beat without sop has seq_base=0.
- Random valid/ready stress with NUM_LANES=1 and 8 against a scoreboard -> no drop, no duplicate, fields match the reference model.
